// File: rtl/regfile_write_queue.sv
// ----------------------------------------------------------------------------
// regfile_write_queue
//
// Write-side producer for the 32x64 register file. Completed results
// (register index + value) are buffered in a small circular FIFO and drained
// one per cycle onto the register file's single write port. Two combinational
// bypass lookups expose the youngest pending value for a register so the read
// side can see writes that have not reached the array yet.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; discards every pending entry
//   in_valid       producer presents a result this cycle
//   in_ready       queue can accept a result (not full)
//   in_reg         destination register index
//   in_data        result value
//   drain_en       register file write port is available this cycle
//   RegWrite       write enable to the register file
//   WriteRegister  write index to the register file (head entry)
//   WriteData      write data to the register file (head entry)
//   lookup_reg1/2  bypass query indices
//   lookup_hit1/2  a pending write exists for the queried index
//   lookup_data1/2 youngest pending value for the queried index (0 on miss)
//   count          number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module regfile_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     drain_en,
    output logic                     RegWrite,
    output logic [4:0]               WriteRegister,
    output logic [WIDTH-1:0]         WriteData,
    input  logic [4:0]               lookup_reg1,
    input  logic [4:0]               lookup_reg2,
    output logic                     lookup_hit1,
    output logic                     lookup_hit2,
    output logic [WIDTH-1:0]         lookup_data1,
    output logic [WIDTH-1:0]         lookup_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [4:0]  ZeroReg = 5'd31;

    // Entry storage
    logic [4:0]       reg_q   [DEPTH];
    logic [4:0]       reg_d   [DEPTH];
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Last drained entry; drives the write port while the queue is empty
    logic [4:0]       last_reg_q, last_reg_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;

    logic             empty;
    logic             push;
    logic             pop;

    logic [PtrW-1:0]  idx1;
    logic [PtrW-1:0]  idx2;

    // ------------------------------------------------------------------------
    // Handshake and drain control
    // ------------------------------------------------------------------------
    always_comb begin
        empty    = (count_q == '0);
        in_ready = (count_q != CntW'(DEPTH));
        RegWrite = !empty && drain_en;
        // X31 completes the handshake but is dropped: it is hardwired zero.
        push     = in_valid && in_ready && (in_reg != ZeroReg);
        pop      = RegWrite;
    end

    always_comb begin
        WriteRegister = empty ? last_reg_q  : reg_q[rd_ptr_q];
        WriteData     = empty ? last_data_q : data_q[rd_ptr_q];
        count         = count_q;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // A push and a pop never target the same slot: wr_ptr == rd_ptr only when
    // empty (no pop) or full (no push).
    always_comb begin
        reg_d       = reg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_reg_d  = last_reg_q;
        last_data_d = last_data_q;
        count_d     = count_q;

        if (push) begin
            reg_d[wr_ptr_q]   = in_reg;
            data_d[wr_ptr_q]  = in_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PtrW'(1);
            last_reg_d        = reg_q[rd_ptr_q];
            last_data_d       = data_q[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_reg_q  <= '0;
            last_data_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                reg_q[i]  <= reg_d[i];
                data_q[i] <= data_d[i];
            end
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_reg_q  <= last_reg_d;
            last_data_q <= last_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Bypass lookups
    // ------------------------------------------------------------------------
    // Scan oldest to youngest so the last match wins (youngest pending value).
    // The head being drained this cycle is still valid, so it still hits.
    always_comb begin
        lookup_hit1  = 1'b0;
        lookup_data1 = '0;
        idx1         = rd_ptr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx1 = rd_ptr_q + PtrW'(i);
            if (valid_q[idx1] && (reg_q[idx1] == lookup_reg1) && (lookup_reg1 != ZeroReg)) begin
                lookup_hit1  = 1'b1;
                lookup_data1 = data_q[idx1];
            end
        end
    end

    always_comb begin
        lookup_hit2  = 1'b0;
        lookup_data2 = '0;
        idx2         = rd_ptr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx2 = rd_ptr_q + PtrW'(i);
            if (valid_q[idx2] && (reg_q[idx2] == lookup_reg2) && (lookup_reg2 != ZeroReg)) begin
                lookup_hit2  = 1'b1;
                lookup_data2 = data_q[idx2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_queue
//
// Directed bench for regfile_write_queue (DEPTH=4, WIDTH=64). Each task drives
// one scenario and compares DUT outputs against hand-computed values.
// Inputs change and outputs are sampled shortly after the rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_write_queue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [63:0] in_data;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  lookup_reg1;
    logic [4:0]  lookup_reg2;
    logic        lookup_hit1;
    logic        lookup_hit2;
    logic [63:0] lookup_data1;
    logic [63:0] lookup_data2;
    logic [2:0]  count;

    int checks;
    int failures;

    regfile_write_queue #(
        .DEPTH (4),
        .WIDTH (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .drain_en      (drain_en),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .lookup_reg1   (lookup_reg1),
        .lookup_reg2   (lookup_reg2),
        .lookup_hit1   (lookup_hit1),
        .lookup_hit2   (lookup_hit2),
        .lookup_data1  (lookup_data1),
        .lookup_data2  (lookup_data2),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++; if (count !== 3'd0) begin failures++;
            $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (RegWrite !== 1'b0) begin failures++;
            $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (lookup_hit1 !== 1'b0 || lookup_hit2 !== 1'b0) begin failures++;
            $display("FAIL reset_hits got=%b%b exp=00", lookup_hit1, lookup_hit2); end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_reg = 5'd5; in_data = 64'hDEAD_BEEF; drain_en = 1'b1;
        #1;
        checks++; if (RegWrite !== 1'b0) begin failures++;
            $display("FAIL lat_no_bypass got=%b exp=0", RegWrite); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b1) begin failures++;
            $display("FAIL lat_regwrite got=%b exp=1", RegWrite); end
        checks++; if (WriteRegister !== 5'd5) begin failures++;
            $display("FAIL lat_wreg got=%0d exp=5", WriteRegister); end
        checks++; if (WriteData !== 64'hDEAD_BEEF) begin failures++;
            $display("FAIL lat_wdata got=%h exp=deadbeef", WriteData); end
        step();
        checks++; if (count !== 3'd0) begin failures++;
            $display("FAIL lat_count got=%0d exp=0", count); end
        checks++; if (RegWrite !== 1'b0) begin failures++;
            $display("FAIL lat_idle got=%b exp=0", RegWrite); end
        checks++; if (WriteRegister !== 5'd5 || WriteData !== 64'hDEAD_BEEF) begin failures++;
            $display("FAIL lat_hold got=%0d/%h exp=5/deadbeef", WriteRegister, WriteData); end
    endtask

    task automatic test_fill_and_drain();
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 64'h100 + 64'(i);
            step();
        end
        in_reg = 5'd9; in_data = 64'h999;
        #1;
        checks++; if (count !== 3'd4) begin failures++;
            $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++;
            $display("FAIL fill_ready got=%b exp=0", in_ready); end
        step();
        checks++; if (count !== 3'd4) begin failures++;
            $display("FAIL fill_held got=%0d exp=4", count); end
        in_valid = 1'b0; drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(i)) begin failures++;
                $display("FAIL drain_order got=%b/%0d exp=1/%0d", RegWrite, WriteRegister, i); end
            checks++; if (WriteData !== 64'h100 + 64'(i)) begin failures++;
                $display("FAIL drain_data got=%h exp=%h", WriteData, 64'h100 + 64'(i)); end
            step();
        end
        checks++; if (count !== 3'd0 || RegWrite !== 1'b0) begin failures++;
            $display("FAIL drain_empty got=%0d/%b exp=0/0", count, RegWrite); end
    endtask

    task automatic test_lookup();
        drain_en = 1'b0;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 64'h11;
        step();
        in_data = 64'h22;
        step();
        in_data = 64'h33; lookup_reg1 = 5'd7; lookup_reg2 = 5'd8;
        #1;
        checks++; if (lookup_hit1 !== 1'b1 || lookup_data1 !== 64'h22) begin failures++;
            $display("FAIL lk_youngest got=%b/%h exp=1/22", lookup_hit1, lookup_data1); end
        checks++; if (lookup_hit2 !== 1'b0 || lookup_data2 !== 64'h0) begin failures++;
            $display("FAIL lk_miss got=%b/%h exp=0/0", lookup_hit2, lookup_data2); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (lookup_data1 !== 64'h33 || count !== 3'd3) begin failures++;
            $display("FAIL lk_after_accept got=%h/%0d exp=33/3", lookup_data1, count); end
        drain_en = 1'b1;
        #1;
        checks++; if (RegWrite !== 1'b1 || WriteData !== 64'h11) begin failures++;
            $display("FAIL lk_drain_head got=%b/%h exp=1/11", RegWrite, WriteData); end
        checks++; if (lookup_hit1 !== 1'b1 || lookup_data1 !== 64'h33) begin failures++;
            $display("FAIL lk_during_drain got=%b/%h exp=1/33", lookup_hit1, lookup_data1); end
        step(); step(); step();
        checks++; if (count !== 3'd0 || lookup_hit1 !== 1'b0 || lookup_data1 !== 64'h0) begin
            failures++;
            $display("FAIL lk_drained got=%0d/%b/%h exp=0/0/0", count, lookup_hit1, lookup_data1);
        end
    endtask

    task automatic test_x31();
        drain_en = 1'b1; in_valid = 1'b1; in_reg = 5'd31; in_data = 64'hFFFF;
        lookup_reg1 = 5'd31;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++;
            $display("FAIL x31_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || RegWrite !== 1'b0) begin failures++;
            $display("FAIL x31_dropped got=%0d/%b exp=0/0", count, RegWrite); end
        checks++; if (lookup_hit1 !== 1'b0 || lookup_data1 !== 64'h0) begin failures++;
            $display("FAIL x31_lookup got=%b/%h exp=0/0", lookup_hit1, lookup_data1); end
        step();
        checks++; if (RegWrite !== 1'b0) begin failures++;
            $display("FAIL x31_late got=%b exp=0", RegWrite); end
    endtask

    task automatic test_full_wrap();
        int exp_q[$];
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 64'(i);
            step();
        end
        exp_q = '{11, 12, 13};
        in_reg = 5'd20; drain_en = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || RegWrite !== 1'b1 || WriteRegister !== 5'd10) begin
            failures++;
            $display("FAIL full_refuse got=%b/%b/%0d exp=0/1/10", in_ready, RegWrite,
                     WriteRegister);
        end
        step();
        checks++; if (count !== 3'd3) begin failures++;
            $display("FAIL full_count got=%0d exp=3", count); end
        for (int k = 0; k < 10; k++) begin
            in_reg = 5'(20 + k); in_data = 64'(k);
            #1;
            checks++; if (WriteRegister !== 5'(exp_q[0]) || RegWrite !== 1'b1) begin failures++;
                $display("FAIL wrap_head k=%0d got=%0d exp=%0d", k, WriteRegister, exp_q[0]); end
            exp_q.push_back(20 + k);
            void'(exp_q.pop_front());
            step();
            checks++; if (count !== 3'd3) begin failures++;
                $display("FAIL wrap_count k=%0d got=%0d exp=3", k, count); end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (WriteRegister !== 5'(exp_q[0])) begin failures++;
                $display("FAIL wrap_tail got=%0d exp=%0d", WriteRegister, exp_q[0]); end
            void'(exp_q.pop_front());
            step();
        end
        checks++; if (count !== 3'd0) begin failures++;
            $display("FAIL wrap_empty got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid_drain();
        drain_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_reg = 5'(i); in_data = 64'(i);
            step();
        end
        in_valid = 1'b0; drain_en = 1'b1; lookup_reg1 = 5'd1;
        #1;
        checks++; if (RegWrite !== 1'b1 || count !== 3'd3) begin failures++;
            $display("FAIL rst_pre got=%b/%0d exp=1/3", RegWrite, count); end
        reset = 1'b1;
        #1;
        checks++; if (RegWrite !== 1'b0 || count !== 3'd0) begin failures++;
            $display("FAIL rst_immediate got=%b/%0d exp=0/0", RegWrite, count); end
        checks++; if (lookup_hit1 !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL rst_state got=%b/%b exp=0/1", lookup_hit1, in_ready); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (RegWrite !== 1'b0) begin failures++;
                $display("FAIL rst_after got=%b exp=0", RegWrite); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b0;
        lookup_reg1 = '0; lookup_reg2 = '0;
        test_reset();
        test_latency();
        test_fill_and_drain();
        test_lookup();
        test_x31();
        test_full_wrap();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
